// File: rtl/interrupt_ctrl_if.sv
// Bus control and interrupt handshake signals shared between the
// interrupt controller (slave) and its environment (master).
interface interrupt_ctrl_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [1:0] SRC_RAISE;
  logic [1:0] SRC_ACK;
  logic [1:0] CPU_RAISE;
  logic [1:0] CPU_ACK;

  modport slave (
    input  BUS_ADDR, BUS_WE, SRC_RAISE, CPU_ACK,
    output SRC_ACK, CPU_RAISE
  );

  modport master (
    output BUS_ADDR, BUS_WE, SRC_RAISE, CPU_ACK,
    input  SRC_ACK, CPU_RAISE
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Two-source edge-triggered interrupt controller with mask/W1C register
// window and a one-at-a-time presentation FSM (bit1 has priority).
module interrupt_ctrl #(
  parameter logic [7:0] BaseAddr    = 8'hE0,
  parameter logic [1:0] InitialMask = 2'b11
) (
  input  logic            CLK,
  input  logic            RESET,
  inout  wire  [7:0]      BUS_DATA,
  interrupt_ctrl_if.slave bus
);
  localparam logic [7:0] StatusAddr = BaseAddr;
  localparam logic [7:0] MaskAddr   = BaseAddr + 8'd1;
  localparam logic [7:0] ClearAddr  = BaseAddr + 8'd2;

  typedef enum logic [1:0] {IDLE, RAISE, HOLD} state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic [1:0] pending_q, pending_d;
  logic [1:0] mask_q, mask_d;
  logic [1:0] src_q;
  logic [7:0] rdata_q, rdata_d;
  logic       rd_en_q, rd_en_d;

  logic [1:0] events;
  logic [1:0] eligible;
  logic [1:0] sel_onehot;
  logic [1:0] ack_clr;
  logic [1:0] w1c_clr;
  logic       wr_mask;
  logic       wr_clear;

  assign events     = bus.SRC_RAISE & ~src_q;
  assign eligible   = pending_q & mask_q;
  assign sel_onehot = sel_q ? 2'b10 : 2'b01;
  assign wr_mask    = bus.BUS_WE && (bus.BUS_ADDR == MaskAddr);
  assign wr_clear   = bus.BUS_WE && (bus.BUS_ADDR == ClearAddr);
  assign w1c_clr    = wr_clear ? BUS_DATA[1:0] : 2'b00;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack_clr = 2'b00;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          sel_d   = eligible[1];
          state_d = RAISE;
        end
      end
      RAISE: begin
        // Only the ack for the presented source counts; the selection stays
        // latched even if its pending/mask bits change meanwhile.
        if (bus.CPU_ACK[sel_q]) begin
          ack_clr = sel_onehot;
          state_d = HOLD;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new edge overrides any clear (ack or W1C) landing on the same bit.
  assign pending_d = (pending_q & ~(ack_clr | w1c_clr)) | events;
  assign mask_d    = wr_mask ? BUS_DATA[1:0] : mask_q;

  assign rd_en_d = !bus.BUS_WE &&
                   ((bus.BUS_ADDR == StatusAddr) || (bus.BUS_ADDR == MaskAddr));
  assign rdata_d = (bus.BUS_ADDR == StatusAddr) ? {4'b0000, mask_q, pending_q}
                                                : {6'b000000, mask_q};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      pending_q <= 2'b00;
      mask_q    <= InitialMask;
      src_q     <= 2'b00;
      rdata_q   <= 8'h00;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      src_q     <= bus.SRC_RAISE;
      rdata_q   <= rdata_d;
      rd_en_q   <= rd_en_d;
    end
  end

  // Outputs decode straight from state so reset removes them without a clock.
  assign bus.CPU_RAISE = (state_q == RAISE) ? sel_onehot : 2'b00;
  assign bus.SRC_ACK   = (state_q == HOLD)  ? sel_onehot : 2'b00;
  assign BUS_DATA      = rd_en_q ? rdata_q : 8'hzz;
endmodule
